// File: rtl/dma_timing_ctrl.sv
// dma_timing_ctrl: 8237-style DMA transfer-cycle sequencer (hold handshake, S0-S4 bus cycles, address/count update, writeback)
// Ports: CLK/RESET_N (async active-low); valid_dreq, ch_sel, mode, xfer_type, auto_init from the priority block;
// cur_*/base_* register-file values of the granted channel; hlda/ready/eop_n from the bus; hrq, aen, adstb,
// dack_en, ch_out, addr, active-low strobes, tc and the wb_valid/wb_addr/wb_count writeback to the register file.
// Option: DMA_COMPRESSED_TIMING_EN drops S3 (both strobes and the ready sample move into S2).
module dma_timing_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              valid_dreq,
  input  logic [1:0]        ch_sel,
  input  logic [1:0]        mode,
  input  logic [1:0]        xfer_type,
  input  logic              auto_init,
  input  logic [ADDR_W-1:0] cur_addr_in,
  input  logic [CNT_W-1:0]  cur_count_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [CNT_W-1:0]  base_count_in,
  input  logic              hlda,
  input  logic              ready,
  input  logic              eop_n,
  output logic              hrq,
  output logic              aen,
  output logic              adstb,
  output logic              dack_en,
  output logic [1:0]        ch_out,
  output logic [ADDR_W-1:0] addr,
  output logic              memr_n,
  output logic              memw_n,
  output logic              ior_n,
  output logic              iow_n,
  output logic              tc,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [CNT_W-1:0]  wb_count
);
  typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] count;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0] count_dec;
  logic eop_l, tc_hit, done, is_rd, is_wr, rd_on, wr_on;
  assign addr_inc = addr + ADDR_W'(1);
  assign count_dec = count - CNT_W'(1);
  assign tc_hit = count == '0;
  // single (01) and reserved (11) both release after one transfer
  assign done = tc_hit | eop_l | mode[0] | (mode == 2'b00 & ~valid_dreq);
  assign is_rd = xfer_type == 2'b10;
  assign is_wr = xfer_type == 2'b01;
  assign rd_on = nxt inside {S2, S3, SW};
`ifdef DMA_COMPRESSED_TIMING_EN
  assign wr_on = rd_on;
`else
  assign wr_on = nxt inside {S3, SW};
`endif
  always_comb begin
    nxt = state;
    case (state)
      SI: nxt = valid_dreq ? S0 : SI;
      S0: nxt = hlda ? S1 : (valid_dreq ? S0 : SI);
      S1: nxt = S2;
`ifdef DMA_COMPRESSED_TIMING_EN
      S2: nxt = ready ? S4 : SW;
`else
      S2: nxt = S3;
      S3: nxt = ready ? S4 : SW;
`endif
      SW: nxt = ready ? S4 : SW;
      // crossing a 256-byte page needs a fresh upper-address strobe
      S4: nxt = done ? SI : (addr_inc[7:0] == 8'h00 ? S1 : S2);
      default: nxt = SI;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= SI;
    else state <= nxt;
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hrq <= 1'b0;
      aen <= 1'b0;
      adstb <= 1'b0;
      dack_en <= 1'b0;
      tc <= 1'b0;
      wb_valid <= 1'b0;
      memr_n <= 1'b1;
      memw_n <= 1'b1;
      ior_n <= 1'b1;
      iow_n <= 1'b1;
      ch_out <= '0;
      addr <= '0;
      count <= '0;
      wb_addr <= '0;
      wb_count <= '0;
      eop_l <= 1'b0;
    end else begin
      hrq <= nxt != SI;
      aen <= !(nxt inside {SI, S0});
      dack_en <= !(nxt inside {SI, S0});
      adstb <= nxt == S1;
      memr_n <= ~(is_rd & rd_on);
      ior_n <= ~(is_wr & rd_on);
      iow_n <= ~(is_rd & wr_on);
      memw_n <= ~(is_wr & wr_on);
      tc <= nxt == S4 & tc_hit;
      wb_valid <= state == S4 & nxt == SI;
      // EOP is held until the S4 decision has consumed it
      eop_l <= (state inside {S1, S2, S3, SW}) & (eop_l | ~eop_n);
      if (state == SI & valid_dreq) begin
        ch_out <= ch_sel;
        addr <= cur_addr_in;
        count <= cur_count_in;
      end
      if (state == S4) begin
        addr <= addr_inc;
        count <= count_dec;
      end
      if (state == S4 & nxt == SI) begin
        wb_addr <= tc_hit & auto_init ? base_addr_in : addr_inc;
        wb_count <= tc_hit & auto_init ? base_count_in : count_dec;
      end
    end
  end
endmodule

// File: tb/tb_dma_timing_ctrl.sv
// tb_dma_timing_ctrl: scoreboard bench for dma_timing_ctrl
module tb_dma_timing_ctrl;
`ifdef DMA_COMPRESSED_TIMING_EN
  localparam int LOWS = 1;
  localparam int TX = 2;
  localparam bit S2W = 1'b0;
`else
  localparam int LOWS = 2;
  localparam int TX = 3;
  localparam bit S2W = 1'b1;
`endif
  typedef struct {
    bit wb;
    logic [15:0] a;
    logic [15:0] c;
    logic [3:0] stb;
    bit tc;
    bit s1;
    int lows;
    int gap;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_dreq = 1'b0, hlda = 1'b0, auto_init = 1'b0, ready, eop_n;
  logic [1:0] ch_sel = '0, mode = '0, xfer_type = '0;
  logic [15:0] cur_addr_in = '0, cur_count_in = '0, base_addr_in = '0, base_count_in = '0;
  logic hrq, aen, adstb, dack_en, memr_n, memw_n, ior_n, iow_n, tc, wb_valid;
  logic [1:0] ch_out;
  logic [15:0] addr, wb_addr, wb_count;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, nx = 0, ws_req = 0, ws_cnt = 0, eop_at = -1;
  logic [3:0] stb, last_stb;
  int lows = 0, last_cyc = 0;
  bit prev_low = 0, s1_seen = 0;
  exp_t e;
  dma_timing_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .valid_dreq(valid_dreq), .ch_sel(ch_sel), .mode(mode),
    .xfer_type(xfer_type), .auto_init(auto_init), .cur_addr_in(cur_addr_in),
    .cur_count_in(cur_count_in), .base_addr_in(base_addr_in), .base_count_in(base_count_in),
    .hlda(hlda), .ready(ready), .eop_n(eop_n), .hrq(hrq), .aen(aen), .adstb(adstb),
    .dack_en(dack_en), .ch_out(ch_out), .addr(addr), .memr_n(memr_n), .memw_n(memw_n),
    .ior_n(ior_n), .iow_n(iow_n), .tc(tc), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_count(wb_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_x(input logic [15:0] a, input logic [3:0] s, input bit t, input bit s1, input int gap, input int ws);
    exp_t x;
    x = '{wb: 1'b0, a: a, c: 16'h0, stb: s, tc: t, s1: s1, lows: LOWS + ws, gap: gap};
    sb.push_back(x);
  endtask
  task automatic push_wb(input logic [15:0] a, input logic [15:0] c);
    exp_t x;
    x = '{wb: 1'b1, a: a, c: c, stb: 4'hF, tc: 1'b0, s1: 1'b0, lows: 0, gap: 0};
    sb.push_back(x);
  endtask
  task automatic req(input logic [1:0] ch, input logic [15:0] a, input logic [15:0] c, input logic [1:0] md,
                     input logic [1:0] xt, input logic ai, input logic [15:0] ba, input logic [15:0] bc);
    @(negedge clk);
    ch_sel = ch; cur_addr_in = a; cur_count_in = c; mode = md; xfer_type = xt;
    auto_init = ai; base_addr_in = ba; base_count_in = bc; valid_dreq = 1'b1;
    @(posedge clk); #1;
    check("hrq_lat", {31'd0, hrq}, 1);
    check("ch_out", {30'd0, ch_out}, {30'd0, ch});
    @(negedge clk);
    hlda = 1'b1;
    valid_dreq = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((hrq || sb.size() != 0) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("idle", {30'd0, hrq, sb.size() != 0}, 0);
    sb.delete();
    hlda = 1'b0;
    @(negedge clk);
  endtask
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // bus-side responder: wait states once the write strobe is up, EOP during S2 of a chosen transfer
  initial begin
    ready = 1'b1;
    eop_n = 1'b1;
    forever begin
      @(negedge clk);
      if (!aen) ws_cnt = 0;
      if ((memw_n == 1'b0 || iow_n == 1'b0) && ws_cnt < ws_req) begin
        ready = 1'b0;
        ws_cnt++;
      end else ready = 1'b1;
      eop_n = !(eop_at >= 0 && nx == eop_at && (memr_n == 1'b0 || ior_n == 1'b0));
    end
  end
  // monitor: a transfer completes when the strobes rise into S4 while the bus is still held
  initial forever begin
    @(negedge clk);
    stb = {memr_n, memw_n, ior_n, iow_n};
    if (!rst_n) begin
      lows = 0; prev_low = 0; s1_seen = 0;
    end else begin
      if (adstb) s1_seen = 1;
      if (stb != 4'hF) begin
        lows++;
        last_stb = stb;
        prev_low = 1;
      end else if (prev_low && aen) begin
        prev_low = 0;
        if (sb.size() == 0) check("unexp_xfer", 1, 0);
        else begin
          e = sb.pop_front();
          check("kind_x", 0, {31'd0, e.wb});
          check("x_addr", {16'd0, addr}, {16'd0, e.a});
          check("x_stb", {28'd0, last_stb}, {28'd0, e.stb});
          check("x_tc", {31'd0, tc}, {31'd0, e.tc});
          check("x_s1", {31'd0, s1_seen}, {31'd0, e.s1});
          check("x_lows", lows, e.lows);
          if (e.gap != 0) check("x_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc; lows = 0; s1_seen = 0; nx++;
      end
      if (wb_valid) begin
        if (sb.size() == 0) check("unexp_wb", 1, 0);
        else begin
          e = sb.pop_front();
          check("kind_wb", 1, {31'd0, e.wb});
          check("wb_addr", {16'd0, wb_addr}, {16'd0, e.a});
          check("wb_count", {16'd0, wb_count}, {16'd0, e.c});
          check("wb_rel", {29'd0, hrq, aen, dack_en}, 0);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctl", {22'd0, hrq, aen, adstb, dack_en, tc, wb_valid, memr_n, memw_n, ior_n, iow_n}, 32'h00F);
    check("rst_addr", {14'd0, addr, ch_out}, 0);
    check("rst_wb", {wb_addr, wb_count}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // single write, ch2, cycle-by-cycle
    push_x(16'h1000, 4'b1001, 1'b0, 1'b1, 0, 0);
    push_wb(16'h1001, 16'd4);
    req(2'd2, 16'h1000, 16'd5, 2'b01, 2'b01, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    check("s1", {13'd0, aen, adstb, dack_en, addr}, {13'd0, 3'b111, 16'h1000});
    @(posedge clk); #1;
    check("s2", {27'd0, ior_n, memw_n, memr_n, iow_n, adstb}, {27'd0, 1'b0, S2W, 3'b110});
`ifndef DMA_COMPRESSED_TIMING_EN
    @(posedge clk); #1;
    check("s3", {30'd0, ior_n, memw_n}, 0);
`endif
    @(posedge clk); #1;
    check("s4", {12'd0, aen, ior_n, memw_n, tc, addr}, {12'd0, 4'b1110, 16'h1000});
    @(posedge clk); #1;
    check("si", {12'd0, hrq, aen, dack_en, wb_valid, addr}, {12'd0, 4'b0001, 16'h1001});
    wait_idle();
    // block read across a page boundary, runs to TC
    push_x(16'h10FE, 4'b0110, 1'b0, 1'b1, 0, 0);
    push_x(16'h10FF, 4'b0110, 1'b0, 1'b0, TX, 0);
    push_x(16'h1100, 4'b0110, 1'b1, 1'b1, TX + 1, 0);
    push_wb(16'h1101, 16'hFFFF);
    req(2'd1, 16'h10FE, 16'd2, 2'b10, 2'b10, 1'b0, 16'h0, 16'h0);
    wait_idle();
    // block with auto-init, count 0
    push_x(16'h7777, 4'b1001, 1'b1, 1'b1, 0, 0);
    push_wb(16'h2000, 16'd3);
    req(2'd0, 16'h7777, 16'd0, 2'b10, 2'b01, 1'b1, 16'h2000, 16'd3);
    wait_idle();
    // three wait states
    ws_req = 3;
    push_x(16'h0040, 4'b0110, 1'b1, 1'b1, 0, 3);
    push_wb(16'h0041, 16'hFFFF);
    req(2'd3, 16'h0040, 16'd0, 2'b01, 2'b10, 1'b0, 16'h0, 16'h0);
    wait_idle();
    ws_req = 0;
    // EOP during S2 of the second block transfer
    eop_at = nx + 1;
    push_x(16'h3000, 4'b1001, 1'b0, 1'b1, 0, 0);
    push_x(16'h3001, 4'b1001, 1'b0, 1'b0, TX, 0);
    push_wb(16'h3002, 16'd8);
    req(2'd2, 16'h3000, 16'd10, 2'b10, 2'b01, 1'b0, 16'h0, 16'h0);
    wait_idle();
    eop_at = -1;
    // reset while in SW
    ws_req = 20;
    req(2'd1, 16'h4000, 16'd5, 2'b10, 2'b10, 1'b0, 16'h0, 16'h0);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst", {30'd0, memr_n, iow_n}, 0);
    rst_n = 1'b0;
    #1;
    check("rst_async", {24'd0, memr_n, memw_n, ior_n, iow_n, hrq, aen, dack_en, wb_valid}, 32'hF0);
    ws_req = 0;
    hlda = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_rst", {hrq, wb_valid, addr[13:0], wb_addr}, 0);
    // recovery: single write after reset
    push_x(16'h00FF, 4'b1001, 1'b0, 1'b1, 0, 0);
    push_wb(16'h0100, 16'd0);
    req(2'd3, 16'h00FF, 16'd1, 2'b11, 2'b01, 1'b0, 16'h0, 16'h0);
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_timing_ctrl.md
# dma_timing_ctrl

Transfer-cycle sequencer for the 8237-style DMA controller. It sits between the priority resolver and the system bus. On a valid request it performs the hold handshake, latches the granted channel's current address and count, and steps the S0–S4 state machine. It drives address, strobes and the DACK enable, updates address and count, and writes them back to the register file on release.

## Interface
- ADDR_W, 16, current-address width
- CNT_W, 16, current-word-count width

- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- valid_dreq  in  1  any unmasked valid request, from priority block
- ch_sel  in  2  granted channel, from priority block
- mode  in  2  00 demand, 01 single, 10 block, 11 reserved (treated as single)
- xfer_type  in  2  00 verify, 01 write (IOR+MEMW), 10 read (MEMR+IOW), 11 reserved (treated as verify)
- auto_init  in  1  reload from base on TC
- cur_addr_in / cur_count_in  in  ADDR_W / CNT_W  selected channel's current registers
- base_addr_in / base_count_in  in  ADDR_W / CNT_W  selected channel's base registers
- hlda  in  1  hold acknowledge from CPU
- ready  in  1  bus ready; low inserts wait states
- eop_n  in  1  external end-of-process, active low
- hrq  out  1  hold request
- aen  out  1  address enable
- adstb  out  1  upper-address strobe
- dack_en  out  1  drives validDACK to priority block
- ch_out  out  2  latched serviced channel
- addr  out  ADDR_W  transfer address
- memr_n, memw_n, ior_n, iow_n  out  1 each  bus strobes, active low
- tc  out  1  terminal count pulse
- wb_valid  out  1  writeback strobe for wb_addr/wb_count
- wb_addr / wb_count  out  ADDR_W / CNT_W  updated current values

## Operation
- States: SI, S0, S1, S2, S3, SW, S4. One-hot or encoded; the choice is not visible externally.
- SI: idle. On valid_dreq, go to S0 and latch ch_sel, cur_addr_in and cur_count_in.
- S0: hrq=1. On hlda=1, go to S1. If valid_dreq drops before hlda, go to SI.
- S1: aen=1, adstb=1, dack_en=1, addr valid. Next state is S2.
- S2: assert the read strobe (memr_n for read, ior_n for write; none for verify). Next state is S3.
- S3: also assert the write strobe (iow_n for read, memw_n for write). Sample ready: 1 goes to S4, 0 goes to SW.
- SW: hold all strobes until ready=1, then go to S4.
- S4: deassert all strobes. Update addr+1 and count−1, both modulo width.
- TC: when count was 0 in S4 (the count wraps to all-ones), tc=1 for that cycle.
- EOP: eop_n low in any of S1–SW is latched. It terminates the service after the current S4 and does not pulse tc.
- After S4, termination (TC or EOP) releases the bus: wb_valid pulses and the FSM goes to SI.
  - With auto_init=1 on TC, the writeback carries base_addr_in and base_count_in.
- After S4 with no termination:
  - single: writeback, then SI.
  - block: continue.
  - demand: continue while valid_dreq=1, otherwise writeback, then SI.
- Continue: if the new addr[7:0]==0, go to S1 (re-strobe the upper byte); otherwise go to S2.
- On every return to SI, hrq, aen and dack_en drop in the same cycle.

## Timing
- All outputs are registered and are functions of the state (Moore).
- Reset values: hrq, aen, adstb, dack_en, tc and wb_valid are 0; all strobes are 1; addr, ch_out, wb_addr and wb_count are 0; the state is SI.
- Reset mid-transfer clears to SI immediately. No writeback occurs and the strobes go inactive.
- The request-to-hrq latency is 1 cycle.
- A zero-wait transfer from hlda takes 4 cycles (S1, S2, S3, S4). Each subsequent block transfer takes 3 cycles.
- Signals asserted in S4, and wb_valid, are 1-cycle pulses.

## Configuration
- DMA_COMPRESSED_TIMING_EN defined:
  - S3 is removed. Both strobes assert in S2, and ready is sampled in S2 (SW is entered from S2).
  - Block transfers take 2 cycles each.
- DMA_COMPRESSED_TIMING_EN undefined: the full S2, S3 sequence described above applies.

## Test plan
- Single write, ch2, addr 0x1000, count 5, ready=1: hrq, then hlda, then S1–S4. ior_n and memw_n are low. wb_addr=0x1001, wb_count=4, state returns to SI.
- Block read, addr 0x10FE, count 2: three transfers at 0x10FE, 0x10FF and 0x1100. S1 recurs only before 0x1100. tc pulses on the third S4. wb_count=0xFFFF.
- Block, auto_init=1, base 0x2000/3, count 0: tc on the first S4. Writeback gives 0x2000/3.
- ready held low for 3 cycles in S3: 3 SW cycles, strobes stay low, then S4.
- eop_n low during S2 of block transfer #2: that transfer completes, tc=0, wb_valid pulses, state returns to SI.
- RESET_N asserted in SW: all strobes go high and hrq=0 asynchronously. No wb_valid.
